// File: rtl/gf2_31_prng_stream.sv
// Packs successive 31-bit PRNG states LSB-first into 32-bit stream words, one bounded burst per start.
// Optional running XOR checksum output when GF2_31_PRNG_STREAM_CSUM_EN is defined.
module gf2_31_prng_stream #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             prng_enable,
    input  logic [30:0]      prng_word,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef GF2_31_PRNG_STREAM_CSUM_EN
    ,
    output logic [31:0]      csum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [61:0]      acc;
    logic [5:0]       fill;
    logic [LEN_W-1:0] remaining;

    logic             fire;
    logic [5:0]       post;
    logic [LEN_W-1:0] rem_after;
    logic [61:0]      acc_shift;
    logic [61:0]      acc_next;
    logic [5:0]       fill_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (fire && (remaining == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The PRNG only advances when the bits left after this edge's pop fall short
    // of a word and at least one more word is still owed downstream.
    always_comb begin
        busy        = (state == RUN);
        done        = (state == DONE);
        out_valid   = busy && (fill >= 6'd32);
        out_data    = acc[31:0];
        fire        = out_valid && out_ready;
        post        = fill - (fire ? 6'd32 : 6'd0);
        rem_after   = remaining - LEN_W'(fire);
        prng_enable = busy && (post < 6'd32) && (rem_after != '0);
    end

    always_comb begin
        acc_shift = fire ? {32'b0, acc[61:32]} : acc;
        acc_next  = acc_shift;
        fill_next = post;
        if (prng_enable) begin
            acc_next  = acc_shift | ({31'b0, prng_word} << post);
            fill_next = post + 6'd31;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            fill      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        remaining <= len;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    fill <= fill_next;
                    if (fire) begin
                        remaining <= rem_after;
                    end
                end
                DONE: begin
                    acc  <= '0;
                    fill <= '0;
                end
                default: begin
                    acc  <= '0;
                    fill <= '0;
                end
            endcase
        end
    end

`ifdef GF2_31_PRNG_STREAM_CSUM_EN
    // Checksum survives DONE/IDLE so software can read it after the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if (fire) begin
            csum <= csum ^ acc[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_gf2_31_prng_stream.sv
// Scoreboard bench for gf2_31_prng_stream: a stub PRNG feeds bench-chosen words and a
// bit-queue model predicts every packed output word.
module tb_gf2_31_prng_stream;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             prng_enable;
    logic [30:0]      prng_word;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef GF2_31_PRNG_STREAM_CSUM_EN
    logic [31:0]      csum;
`endif

    int checks = 0;
    int failures = 0;

    logic [30:0] stub_words [0:1023];
    logic [30:0] saved_words [0:7];
    logic [9:0]  stub_idx = '0;
    int          ready_mode = 0;
    int          rcyc = 0;
    logic        en_s = 1'b0;

    logic [31:0] exp_q[$];
    int          burst_len = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_fire_cyc = -10;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    assign prng_word = stub_words[stub_idx];

    gf2_31_prng_stream #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .prng_enable(prng_enable),
        .prng_word  (prng_word),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef GF2_31_PRNG_STREAM_CSUM_EN
        ,
        .csum       (csum)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    // Stub PRNG advances one word per enabled edge; out_ready changes just after each edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            en_s = prng_enable;
            @(posedge clk);
            #1;
            if (en_s) stub_idx = stub_idx + 10'd1;
            rcyc++;
            case (ready_mode)
                1:       out_ready = ((rcyc % 3) == 0);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every fire and checks protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(out_valid), 64'd1);
                    check("stall_data_held", 64'(out_data), 64'(prev_data));
                end
                if (out_valid && !out_ready)
                    check("stall_no_enable", 64'(prng_enable), 64'd0);
                if (!busy) begin
                    check("idle_valid_low", 64'(out_valid), 64'd0);
                    check("idle_enable_low", 64'(prng_enable), 64'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_word actual=%0h expected=none", out_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("word", 64'(out_data), 64'(mon_exp));
                    end
                    last_fire_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                    check("done_busy_low", 64'(busy), 64'd0);
                    if (burst_len != 0)
                        check("done_after_last_fire", 64'(cyc), 64'(last_fire_cyc + 1));
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // Loads stub words for the next burst and pushes the model's expected words.
    task automatic prep_burst(input int blen, input int src, output int base, output int need);
        bit          bq[$];
        logic [31:0] w;
        logic [30:0] v;
        logic [9:0]  ix;
        base = int'(stub_idx);
        need = (32 * blen + 30) / 31;
        for (int i = 0; i < need + 4; i++) begin
            case (src)
                1:       v = 31'h7FFFFFFF;
                2:       v = (i == 0) ? 31'h00000001 : (i == 1) ? 31'h00000003 : 31'($urandom);
                3:       v = (i < 8) ? saved_words[i] : 31'($urandom);
                default: v = 31'($urandom);
            endcase
            ix = 10'(base + i);
            stub_words[ix] = v;
            if (i < need)
                for (int b = 0; b < 31; b++) bq.push_back(v[b]);
        end
        for (int k = 0; k < blen; k++) begin
            for (int b = 0; b < 32; b++) w[b] = bq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic run_burst(input int blen, input int src, input int rmode, output int lat);
        int base, need, d0, n;
        bit seen;
        @(negedge clk);
        #2;
        prep_burst(blen, src, base, need);
        ready_mode = rmode;
        burst_len  = blen;
        d0         = done_cnt;
        start      = 1'b1;
        len        = LEN_W'(blen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            if (n == 1) begin
                check("busy_after_start", 64'(busy), 64'(blen != 0));
                #2 start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=none expected=done_pulse");
        end
        lat = n;
        @(negedge clk);
        #2;
        check("enable_count", 64'((int'(stub_idx) - base + 1024) % 1024), 64'(need));
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("all_words_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat, base, need, d0;
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < 1024; i++) stub_words[i] = '0;
        for (int i = 0; i < 8; i++) saved_words[i] = 31'($urandom);

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_enable", 64'(prng_enable), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        #2 rst = 1'b0;

        run_burst(1, 2, 0, lat);
        check("latency_len1", 64'(lat), 64'd4);
`ifdef GF2_31_PRNG_STREAM_CSUM_EN
        check("csum_first", 64'(csum), 64'h80000001);
        run_burst(2, 1, 0, lat);
        check("csum_const_pair", 64'(csum), 64'h00000000);
`endif

        run_burst(62, 1, 0, lat);

        run_burst(4, 3, 1, lat);
        run_burst(4, 3, 0, lat);

        run_burst(0, 0, 0, lat);
        check("latency_len0", 64'(lat), 64'd1);

        // Abort a len=8 burst with reset in its fifth RUN cycle.
        @(negedge clk);
        #2;
        prep_burst(8, 0, base, need);
        ready_mode = 0;
        burst_len  = 8;
        start      = 1'b1;
        len        = LEN_W'(8);
        @(negedge clk);
        #2 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_enable", 64'(prng_enable), 64'd0);
        check("abort_data", 64'(out_data), 64'd0);
        #2 rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_burst(8, 0, 0, lat);

        for (int r = 0; r < 6; r++) begin
            run_burst(int'($urandom_range(1, 20)), 0, 2, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
